// File: rtl/dm_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// FSM encodings, latency counter width, request bundle, byte-lane merge.
package dm_responder_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] DMR_IDLE = 2'd0;
    localparam logic [1:0] DMR_WAIT = 2'd1;
    localparam logic [1:0] DMR_RESP = 2'd2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] pc;
    } dmr_req_t;

    function automatic logic [31:0] merge_be(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_responder_ram.sv
// dmr_ram: single-port DEPTH x 32 word array, byte write enables,
// synchronous clear of every word. Ports: clk, clr, we, idx, be, wdata, rdata.
module dmr_ram
    import dm_responder_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [3:0]               be,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[idx] <= merge_be(mem_q[idx], wdata, be);
        end
    end

    // Combinational read: the FSM samples it on the access edge.
    assign rdata = mem_q[idx];

endmodule

// File: rtl/dm_responder.sv
// dm_responder: memory end of the core load/store port. One request at a
// time over req_valid/req_ready, response after LATENCY wait states over
// resp_valid/resp_ready; resp_err flags addresses outside the array.
// rst is asynchronous active-low. Define DM_TRACE_EN to print each
// performed in-range write (simulation only).
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmr_req_t         req_q, req_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             run_q, run_d;

    logic [31:0]   off;
    logic          addr_err;
    logic [AW-1:0] idx;
    logic [31:0]   ram_rdata;
    logic          ram_we;

    assign off      = req_q.addr - BASE_ADDR;
    assign addr_err = {1'b0, off} >= LIMIT;
    assign idx      = off[AW+1:2];

    // run_q holds req_ready low until the first edge after reset release.
    assign req_ready  = run_q && (state_q == DMR_IDLE);
    assign resp_valid = (state_q == DMR_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        run_d   = 1'b1;
        ram_we  = 1'b0;
        unique case (state_q)
            DMR_IDLE: begin
                if (req_valid && req_ready) begin
                    req_d.we    = req_we;
                    req_d.addr  = req_addr;
                    req_d.be    = req_be;
                    req_d.wdata = req_wdata;
                    req_d.pc    = req_pc;
                    cnt_d       = CNT_INIT;
                    state_d     = DMR_WAIT;
                end
            end
            DMR_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ram_we  = req_q.we && !addr_err;
                    rdata_d = (req_q.we || addr_err) ? '0 : ram_rdata;
                    err_d   = addr_err;
                    state_d = DMR_RESP;
                end
            end
            DMR_RESP: begin
                if (resp_ready) begin
                    state_d = DMR_IDLE;
                end
            end
            default: state_d = DMR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DMR_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            run_q   <= run_d;
        end
    end

    // Memory is cleared on every edge while reset is held, which also
    // drops any captured write that had not been performed yet.
    dmr_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .clr  (!rst),
        .we   (ram_we),
        .idx  (idx),
        .be   (req_q.be),
        .wdata(req_q.wdata),
        .rdata(ram_rdata)
    );

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst && ram_we && (req_q.be != 4'b0000)) begin
            $display("@%08h: *%08h <= %08h", req_q.pc,
                     {req_q.addr[31:2], 2'b00},
                     merge_be(ram_rdata, req_q.wdata, req_q.be));
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_q.pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder (DEPTH=1024, LATENCY=2, BASE 0):
// directed requests push expected responses, a monitor checks them.
module tb_dm_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q[$];
    bit   seen = 1'b0;

    dm_responder #(
        .DEPTH(1024),
        .LATENCY(LAT),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: compares every cycle a response is presented, so values
    // must also stay stable under backpressure; pops on handshake.
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata %08h expected none",
                         resp_rdata);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 32'(cyc - q[0].acc), 32'(LAT));
                end
                chk("rdata", resp_rdata, q[0].rdata);
                chk("err", {31'b0, resp_err}, {31'b0, q[0].err});
                if (resp_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input bit push);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wd;
        req_pc    = 32'h0000_3000 | addr;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got req_ready 0 expected 1");
            req_valid = 1'b0;
            return;
        end
        if (push) q.push_back('{exp_rd, exp_err, cyc + 1});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || !req_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     q.size());
            q.delete();
            seen = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_req_ready_pre", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("rel_req_ready", {31'b0, req_ready}, 32'd1);
        do_req(1'b0, 32'h10, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_idle();

        // Byte-lane writes
        do_req(1'b1, 32'h8, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        do_req(1'b1, 32'h8, 4'b0010, 32'h0000_5500, 32'h0, 1'b0, 1'b1);
        do_req(1'b0, 32'h8, 4'h0, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1);
        do_req(1'b1, 32'h8, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
        do_req(1'b0, 32'hB, 4'hF, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1);
        wait_idle();

        // Backpressure with an illegal extra request held on the port
        resp_ready = 1'b0;
        do_req(1'b0, 32'h8, 4'hF, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h8;
        req_be    = 4'hF;
        req_wdata = 32'h0;
        repeat (7) begin
            @(negedge clk);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        wait_idle();
        do_req(1'b0, 32'h8, 4'hF, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1);
        wait_idle();

        // Range boundaries
        do_req(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        do_req(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        do_req(1'b0, 32'h1000, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
        do_req(1'b0, 32'h0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        do_req(1'b1, 32'hFFC, 4'hF, 32'h01020304, 32'h0, 1'b0, 1'b1);
        do_req(1'b0, 32'hFFC, 4'hF, 32'h0, 32'h01020304, 1'b0, 1'b1);
        do_req(1'b0, 32'hFFFFFFFC, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
        wait_idle();

        // Reset while a write waits
        do_req(1'b1, 32'h4, 4'hF, 32'h12345678, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        end
        do_req(1'b0, 32'h4, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
        do_req(1'b0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder: the memory end of the CPU load/store port.
- Accepts one request at a time over a valid/ready handshake and performs word accesses with per-byte write enables.
- Returns the read data or a write acknowledgement after a fixed, programmable wait-state latency.
- Sits between the pipelined core's MEM stage and the on-chip data RAM; replaces the zero-latency DM for stall-path testing.

Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of two.
- LATENCY, 2: wait-state cycles between request acceptance and response; legal range 1..15.
- BASE_ADDR, 32'h0000_0000: byte address that maps to word 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; bits [1:0] are ignored.
- req_be  in  4  byte enables for writes; bit i enables byte lane i (bits 8i+7:8i).
- req_wdata  in  32  write data, lane-aligned.
- req_pc  in  32  PC of the issuing instruction; used only by the trace feature.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  read data; 0 for writes and for error responses.
- resp_err  out  1  address out of range.

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - FSM goes to IDLE; all memory words are cleared to 0 over the reset period.
  - On the first clk edge after rst deasserts, req_ready=1.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, capture we/addr/be/wdata/pc, load cnt=LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - If cnt!=0, decrement cnt.
  - If cnt==0, perform the access this edge, register resp_*, and go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On resp_ready, go to IDLE with resp_valid=0 on the next cycle.
  - No new request is accepted in the same cycle as response acceptance (no bypass).
- Latency: a request accepted at edge N gives resp_valid=1 after edge N+LATENCY.
- Address mapping:
  - off = req_addr - BASE_ADDR (32-bit, wrapping subtraction).
  - Word index = off[log2(DEPTH)+1:2].
  - Out of range when off >= DEPTH*4. The error is flagged, the write is suppressed and rdata=0.
- Write: mem[idx] lanes with be[i]=1 take wdata lanes; the other lanes keep their value. be=0000 is a legal no-op write.
- Read: resp_rdata = mem[idx] as sampled at the access edge. be is ignored on reads.
- Core protocol violations: req_valid held high while req_ready=0 is ignored (request is not queued). resp_ready while resp_valid=0 is ignored.
- Reset mid-operation: a captured but unperformed write is discarded. The pending response is dropped.

Optional Feature:
- Macro DM_TRACE_EN.
- When defined, each performed in-range write with be!=0 prints, in simulation:
  "@<pc hex8>: *<byte addr hex8> <= <merged word hex8>", using the full word after merging.
- Out-of-range writes print nothing.
- When undefined, no display statements are compiled and behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - FSM state encodings DMR_IDLE/DMR_WAIT/DMR_RESP (2-bit).
  - Lane-merge function merge_be(old, new, be).
  - Localparam for the 4-bit latency counter width.
- One natural sub-module: dmr_ram, a single-port DEPTH x 32 array with byte-write enables and synchronous clear. The FSM and handshake stay in dm_responder.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → req_ready=1 one cycle later; read addr 0x0000_0010 returns resp_rdata=0, resp_err=0.
- Byte write: with LATENCY=2, write addr 0x0000_0008, be=1111, data 0xDEADBEEF; then write be=0010, data 0x0000_5500; then read → 0xDEAD55EF. Each resp_valid rises exactly 2 edges after acceptance.
- Backpressure: read with resp_ready=0 for 5 cycles → resp_valid and rdata stay stable; req_ready=0 throughout; a request driven meanwhile is not executed.
- Out of range: with DEPTH=1024, write addr 0x0000_1000 → resp_err=1, rdata=0; word 0 stays unchanged on readback.
- Reset mid-op: accept a write of 0x12345678 to 0x0000_0004, assert rst during WAIT → resp_valid never rises; a read after reset returns 0.
- Trace: compile with DM_TRACE_EN, req_pc=0x0000_3008, write 0x000000AB with be=0001 to 0x0000_0000 → prints "@00003008: *00000000 <= 000000ab".
